// File: rtl/tx_buf_pkg.sv
// Shared types and constants for the UART transmit-buffer drain stage.
// Optional even parity bit is enabled by defining TX_BUF_PARITY_EN.
package tx_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_SEND  = 2'd3
    } tx_state_e;

    localparam int unsigned DEF_ADDR_W = 20;
    localparam int unsigned DEF_DEPTH  = 200001;

`ifdef TX_BUF_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame serializer: start, 8 data bits LSB first, optional parity (TX_BUF_PARITY_EN), stop.
// A 1-cycle load_i captures the byte; done_o pulses in the last cycle of the stop bit.
module uart_tx_serializer
    import tx_buf_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       txd_o,
    output logic       done_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  active_q, active_d;
    logic [FRAME_BITS-1:0] frame;

    // Whole frame is preloaded so the line simply follows shift_q[0].
`ifdef TX_BUF_PARITY_EN
    assign frame = {1'b1, ^data_i, data_i, 1'b0};
`else
    assign frame = {1'b1, data_i, 1'b0};
`endif

    assign done_o = active_q && (cnt_q == '0) && (idx_q == IDX_LAST);
    assign txd_o  = active_q ? shift_q[0] : 1'b1;

    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        active_d = active_q;
        if (load_i) begin
            shift_d  = frame;
            cnt_d    = CNT_MAX;
            idx_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                if (idx_q == IDX_LAST) begin
                    active_d = 1'b0;
                end else begin
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = CNT_MAX;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/tx_buf_drain.sv
// Drains the UART transmit buffer RAM (1-cycle registered read) onto the TX line.
// Parity bit inserted when TX_BUF_PARITY_EN is defined.
module tx_buf_drain
    import tx_buf_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DEPTH        = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] wr_ptr,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [7:0]        dob,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              txd,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    tx_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_inc;
    logic              ser_load;
    logic              ser_done;

    assign rd_ptr_inc = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        ser_load = 1'b0;
        enb      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_ptr != rd_ptr_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                enb     = 1'b1;
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                ser_load = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                // Emptiness is judged against the advanced pointer in the same cycle.
                if (ser_done) begin
                    rd_ptr_d = rd_ptr_inc;
                    state_d  = (wr_ptr != rd_ptr_inc) ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign addrb  = rd_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign busy   = (state_q != ST_IDLE);

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk_i (clk),
        .rstn_i(rstn),
        .load_i(ser_load),
        .data_i(dob),
        .txd_o (txd),
        .done_o(ser_done)
    );

endmodule

// File: doc/tx_buf_drain.md
# tx_buf_drain

Drain stage downstream of the UART transmit buffer RAM. It compares the producer's write pointer with its own read pointer and fetches pending bytes through the RAM's read port, which has a 1-cycle registered read. It then serialises each byte onto the UART TX line as 8N1, LSB first. The block is the only reader of the buffer and advances its read pointer, with wrap-around, once the stop bit of each byte completes.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200).
- `ADDR_W`, default 20: buffer address width.
- `DEPTH`, default 200001: number of buffer entries; valid addresses are 0..DEPTH-1.
- `clk`  in  1: the single clock; all logic is rising-edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `wr_ptr`  in  ADDR_W: producer's next write address; the buffer is non-empty when `wr_ptr != rd_ptr`.
- `enb`  out  1: read enable to the buffer port B.
- `addrb`  out  ADDR_W: read address to port B.
- `dob`  in  8: read data from port B, valid the cycle after `enb` was sampled high.
- `rd_ptr`  out  ADDR_W: address of the next byte to send; exported to the producer for full detection.
- `txd`  out  1: UART line; idles high.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- States: IDLE, FETCH, LATCH, SEND.
- IDLE:
  - `enb=0`, `txd=1`.
  - If `wr_ptr != rd_ptr`, go to FETCH on the next edge.
- FETCH (1 cycle):
  - Drives `enb=1`, `addrb=rd_ptr`.
  - Goes to LATCH.
- LATCH (1 cycle):
  - `enb=0`.
  - The shift register loads `dob` at the end of this cycle.
  - Goes to SEND.
- SEND sends the frame in this order:
  - Start bit 0.
  - d[0] through d[7].
  - Parity bit, only with the parity option enabled (see Configuration).
  - Stop bit 1.
- Each bit is held for exactly `CLKS_PER_BIT` cycles, counted by a down-counter of width `$clog2(CLKS_PER_BIT)`.
- When the stop bit finishes:
  - `rd_ptr` becomes `rd_ptr+1`, or 0 if `rd_ptr == DEPTH-1`.
  - The next state is FETCH if `wr_ptr` differs from the new `rd_ptr`, otherwise IDLE.
  - The non-empty check uses the incremented pointer value in the same cycle.
- `wr_ptr` is sampled every cycle.
  - Changes to `wr_ptr` during SEND never affect the current frame.
  - The producer guarantees that data at an address is written no later than the edge on which `wr_ptr` advances past it.
- Full/overrun protection is the producer's responsibility. The block never writes the RAM.
- `addrb` holds `rd_ptr` in every state. `enb` is high only in FETCH.

## Timing
- Reset values (asynchronous, applied immediately on `rstn` low):
  - State = IDLE.
  - `txd=1`, `enb=0`, `addrb=0`, `rd_ptr=0`, `busy=0`.
  - Bit counter and shift register cleared.
- Start-up latency, with non-empty first seen in IDLE at edge E:
  - FETCH occupies E..E+1.
  - LATCH occupies E+1..E+2.
  - `txd` falls at edge E+2.
- Frame length is 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- Back-to-back bytes: after the stop bit there are 2 cycles of `txd=1` (FETCH and LATCH) before the next start bit.
- Reset mid-frame:
  - `txd` returns to 1 at once.
  - The partial byte is discarded and is not retransmitted.
  - `rd_ptr` restarts at 0.

## Configuration
- `TX_BUF_PARITY_EN`, when defined: an even-parity bit (XOR of d[7:0]) is inserted between d[7] and the stop bit; the frame is 11 bits.
- When undefined: no parity bit; the frame is 8N1, 10 bits. No parity logic is synthesised.

## Structure
- Shared package `tx_buf_pkg`:
  - State encoding enum (IDLE, FETCH, LATCH, SEND).
  - Default `ADDR_W` and `DEPTH`.
  - `FRAME_BITS` constant, which depends on `TX_BUF_PARITY_EN`.
- Sub-module `uart_tx_serializer`:
  - Accepts a byte with a 1-cycle `load` strobe.
  - Owns the baud counter, bit index and shift register.
  - Returns a `done` pulse in the last cycle of the stop bit.
- The top level holds the FSM, the pointer and the wrap logic.

## Test plan
- Single byte, `CLKS_PER_BIT=4`, RAM[0]=0x55, `wr_ptr` 0→1 → `enb` pulses with `addrb=0`; `txd` shows 0,1,0,1,0,1,0,1,0,1 (4 cycles each); `rd_ptr=1`; `busy` falls.
- Empty buffer, `wr_ptr=rd_ptr=0` for 1000 cycles → `enb=0`, `txd=1`, `busy=0` throughout.
- Back-to-back, RAM[0..2]=0xA5,0x00,0xFF, `wr_ptr=3` → three frames with exactly 2 idle cycles between them; `rd_ptr=3` at the end.
- Wrap-around, `DEPTH=4`, `rd_ptr` at 3, `wr_ptr=1` → sends RAM[3] then RAM[0]; `rd_ptr` goes 3→0→1.
- Reset during d[4] of 0xC3 → `txd=1` immediately, `rd_ptr=0`; after release, byte 0 is resent from its start bit.
- With `TX_BUF_PARITY_EN`, byte 0x07 → parity bit 1, frame 11 bits; byte 0x03 → parity bit 0.
